// File: rtl/pcm_rate_fifo.sv
// ---------------------------------------------------------------------------
// pcm_rate_fifo
//   Stereo frame FIFO that feeds the 16-bit signed l/r inputs of the I2S
//   transmitter. Upstream logic pushes {l,r} frames with a valid/ready
//   handshake. An internal phase accumulator produces one pop strobe per
//   output sample period (lrck_hz), so l/r change exactly once per period.
//   Underruns hold the last frame (or output zero) and are counted.
//
// Optional feature macro: PCM_VOLUME_EN
//   When defined, the vol port exists and popped samples are scaled by
//   vol/128 with saturation in the pop register stage.
//
// Parameters
//   addr_bits      FIFO depth = 2**addr_bits frames (32 bits each)
//   clk_hz         clk frequency in Hz
//   lrck_hz        pop rate in Hz (must match the I2S stage)
//   underrun_zero  0: hold last frame on underrun, 1: output 0/0
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   in_l/in_r  in   16-bit signed samples of the offered frame
//   in_valid   in   frame offered this cycle
//   in_ready   out  frame accepted when in_valid & in_ready
//   vol        in   unsigned gain, 128 = unity (PCM_VOLUME_EN only)
//   l/r        out  registered PCM to I2S, signed
//   tick       out  1-cycle pulse, high in the first cycle showing new l/r
//   level      out  frames currently stored, 0..2**addr_bits
//   underruns  out  saturating underrun count
// ---------------------------------------------------------------------------
module pcm_rate_fifo #(
  parameter int unsigned addr_bits     = 4,
  parameter int unsigned clk_hz        = 25000000,
  parameter int unsigned lrck_hz       = 44100,
  parameter bit          underrun_zero = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          in_l,
  input  logic [15:0]          in_r,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef PCM_VOLUME_EN
  input  logic [7:0]           vol,
`endif
  output logic [15:0]          l,
  output logic [15:0]          r,
  output logic                 tick,
  output logic [addr_bits:0]   level,
  output logic [7:0]           underruns
);

  localparam int unsigned            DEPTH   = 2 ** addr_bits;
  localparam logic [63:0]            INC64   = (64'(lrck_hz) << 32) / 64'(clk_hz);
  localparam logic [31:0]            INC     = INC64[31:0];
  localparam logic [addr_bits:0]     FULL    = (addr_bits + 1)'(DEPTH);
  localparam logic [addr_bits:0]     LVL_ONE = (addr_bits + 1)'(1);
  localparam logic [addr_bits-1:0]   PTR_ONE = addr_bits'(1);

  // Phase accumulator: a full 32-bit wrap corresponds to one output sample
  // period, so the carry out of the add is the pop strobe (registered).
  logic [31:0]          pa_q;
  logic [32:0]          pa_sum;
  logic                 strobe_q;
  logic                 tick_q;

  logic [addr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_bits-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_bits:0]   level_q, level_d;
  logic [15:0]          l_q, r_q;
  logic [7:0]           underruns_q;

  logic [31:0]          mem [DEPTH];
  logic [31:0]          rd_data_q;
  logic [15:0]          pop_l, pop_r;

  logic                 push, pop, underrun;

  assign pa_sum   = {1'b0, pa_q} + {1'b0, INC};

  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign in_ready = (level_q != FULL);
  assign push     = in_valid & in_ready;
  // Emptiness is judged before any same-cycle push: no bypass.
  assign pop      = strobe_q & (level_q != '0);
  assign underrun = strobe_q & (level_q == '0);

  assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Frame storage with a registered read. The read address is the pointer
  // value that will be current after this edge, so rd_data_q always holds
  // the head frame one cycle ahead and the pop stage can take it directly.
  // A write into the slot that becomes the head (FIFO empty after this
  // edge) is forwarded, giving write-first behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_l, in_r};
    end
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      rd_data_q <= {in_l, in_r};
    end else begin
      rd_data_q <= mem[rd_ptr_d];
    end
  end

`ifdef PCM_VOLUME_EN
  // sat16((s * vol) >>> 7); |s*vol| < 2**24 so a 25-bit product is exact.
  function automatic logic [15:0] apply_vol(input logic [15:0] s, input logic [7:0] g);
    logic signed [24:0] s_ext;
    logic signed [24:0] g_ext;
    logic signed [24:0] prod;
    logic signed [24:0] shifted;
    s_ext   = {{9{s[15]}}, s};
    g_ext   = {17'd0, g};
    prod    = s_ext * g_ext;
    shifted = prod >>> 7;
    if (shifted > 25'sd32767) begin
      apply_vol = 16'h7FFF;
    end else if (shifted < -25'sd32768) begin
      apply_vol = 16'h8000;
    end else begin
      apply_vol = shifted[15:0];
    end
  endfunction

  assign pop_l = apply_vol(rd_data_q[31:16], vol);
  assign pop_r = apply_vol(rd_data_q[15:0], vol);
`else
  assign pop_l = rd_data_q[31:16];
  assign pop_r = rd_data_q[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_q        <= '0;
      strobe_q    <= 1'b0;
      tick_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      l_q         <= '0;
      r_q         <= '0;
      underruns_q <= '0;
    end else begin
      pa_q     <= pa_sum[31:0];
      strobe_q <= pa_sum[32];
      // Every strobe, popped or starved, produces a tick alongside l/r.
      tick_q   <= strobe_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (pop) begin
        l_q <= pop_l;
        r_q <= pop_r;
      end else if (underrun) begin
        if (underrun_zero) begin
          l_q <= '0;
          r_q <= '0;
        end
        if (underruns_q != 8'hFF) begin
          underruns_q <= underruns_q + 8'd1;
        end
      end
    end
  end

  assign l         = l_q;
  assign r         = r_q;
  assign tick      = tick_q;
  assign level     = level_q;
  assign underruns = underruns_q;

endmodule

// File: tb/tb_pcm_rate_fifo.sv
// ---------------------------------------------------------------------------
// tb_pcm_rate_fifo
//   Self-checking bench for pcm_rate_fifo. A fast-rate instance is checked
//   every cycle against a queue-based reference model whose pop timing comes
//   from the arithmetic rule "a pop occurs when n*inc crosses a multiple of
//   2**32". A second instance at 25 MHz / 48 kHz checks tick spacing and
//   tick count over ~100 sample periods.
// ---------------------------------------------------------------------------
module tb_pcm_rate_fifo;

  localparam int          AB      = 4;
  localparam int          DEPTH   = 16;
  localparam int          CLK_HZ  = 25000000;
  localparam int          LRCK_HZ = 1000000;
  localparam bit          UZ      = 1'b0;
  localparam longint unsigned INC = (longint'(LRCK_HZ) << 32) / longint'(CLK_HZ);

  localparam int          PACE_N  = 52084;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic [15:0] in_l, in_r;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  vol;
  logic [15:0] l, r;
  logic        tick;
  logic [AB:0] level;
  logic [7:0]  underruns;

  logic        p_valid;
  logic        p_ready;
  logic [15:0] p_l, p_r;
  logic        p_tick;
  logic [4:0]  p_level;
  logic [7:0]  p_und;

  int checks   = 0;
  int failures = 0;

  pcm_rate_fifo #(
    .addr_bits(AB), .clk_hz(CLK_HZ), .lrck_hz(LRCK_HZ), .underrun_zero(UZ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef PCM_VOLUME_EN
    .vol(vol),
`endif
    .l(l), .r(r), .tick(tick), .level(level), .underruns(underruns)
  );

  pcm_rate_fifo #(
    .addr_bits(4), .clk_hz(25000000), .lrck_hz(48000), .underrun_zero(1'b0)
  ) dut_pace (
    .clk(clk), .rst_n(rst2_n), .in_l(16'h0101), .in_r(16'h0202), .in_valid(p_valid),
    .in_ready(p_ready),
`ifdef PCM_VOLUME_EN
    .vol(8'd128),
`endif
    .l(p_l), .r(p_r), .tick(p_tick), .level(p_level), .underruns(p_und)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(950000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]     mq[$];
  logic [15:0]     m_l, m_r;
  bit              m_tick;
  int              m_und;
  longint unsigned m_e;
  bit              m_next_pop;   // a strobe is due: the next edge pops
  bit              m_pop;        // the last edge was a pop or underrun

  function automatic logic [15:0] m_scale(input logic [15:0] s, input logic [7:0] g);
`ifdef PCM_VOLUME_EN
    int p;
    p = int'($signed(s)) * int'(g);
    p = p >>> 7;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_l = '0; m_r = '0; m_tick = 1'b0; m_und = 0;
    m_e = 0; m_next_pop = 1'b0; m_pop = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit v, input logic [15:0] dl, input logic [15:0] dr);
    bit          do_push;
    logic [31:0] f;
    longint unsigned a, b;
    in_valid = v; in_l = dl; in_r = dr;
    @(posedge clk);
    m_e++;
    m_pop   = m_next_pop;
    do_push = v && (mq.size() < DEPTH);
    if (m_pop) begin
      if (mq.size() > 0) begin
        f   = mq.pop_front();
        m_l = m_scale(f[31:16], vol);
        m_r = m_scale(f[15:0], vol);
      end else begin
        if (UZ) begin m_l = '0; m_r = '0; end
        if (m_und < 255) m_und++;
      end
    end
    if (do_push) mq.push_back({dl, dr});
    m_tick = m_pop;
    a = (m_e * INC) >> 32;
    b = ((m_e - 1) * INC) >> 32;
    m_next_pop = (a != b);
    #1;
    check("l", 32'(l), 32'(m_l));
    check("r", 32'(r), 32'(m_r));
    check("tick", 32'(tick), 32'(m_tick));
    check("level", 32'(level), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    check("underruns", 32'(underruns), 32'(m_und));
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0, 16'h0, 16'h0);
      n++;
    end while (!m_pop && n < 64);
    if (!m_pop) begin
      checks++; failures++;
      $display("FAIL %s_wait actual=no_pop required=pop_within_64", tag);
    end
  endtask

  task automatic wait_pre_pop(input string tag);
    int n;
    n = 0;
    while (!m_next_pop && n < 64) begin
      step(1'b0, 16'h0, 16'h0);
      n++;
    end
    if (!m_next_pop) begin
      checks++; failures++;
      $display("FAIL %s_wait actual=no_strobe required=strobe_within_64", tag);
    end
  endtask

  // ---------------- pacing monitor (48 kHz instance) ----------------
  int pace_cyc   = 0;
  int pace_ticks = 0;
  int pace_last  = -1;

  always @(negedge clk) begin
    if (rst2_n) begin
      pace_cyc++;
      if (p_tick && pace_cyc <= PACE_N) begin
        pace_ticks++;
        if (pace_last >= 0) begin
          checks++;
          if ((pace_cyc - pace_last) != 520 && (pace_cyc - pace_last) != 521) begin
            failures++;
            $display("FAIL pace_spacing actual=%0d required=520_or_521", pace_cyc - pace_last);
          end
        end
        pace_last = pace_cyc;
      end
    end
  end

  // ---------------- tables ----------------
  typedef struct {
    logic [15:0] l_in;
    logic [15:0] r_in;
    bit          exp_ready;
    int          exp_level;
  } ord_vec_t;

  typedef struct {
    logic [7:0]  g;
    logic [15:0] s;
    logic [15:0] exp;
  } vol_vec_t;

  ord_vec_t ord_tab[17];
  vol_vec_t vol_tab[5];

  initial begin
    int thr;
    logic [15:0] hold_l;

    for (int k = 1; k <= 17; k++) begin
      ord_tab[k-1].l_in      = 16'(k);
      ord_tab[k-1].r_in      = 16'(-k);
      ord_tab[k-1].exp_ready = (k <= 16);
      ord_tab[k-1].exp_level = (k <= 16) ? k : 16;
    end
    vol_tab[0] = '{8'd128, 16'h7FFF, 16'h7FFF};
    vol_tab[1] = '{8'd255, 16'h7FFF, 16'h7FFF};
    vol_tab[2] = '{8'd255, 16'h8000, 16'h8000};
    vol_tab[3] = '{8'd64,  16'hFC18, 16'hFE0C};
    vol_tab[4] = '{8'd0,   16'h1234, 16'h0000};

    rst_n = 1'b0; rst2_n = 1'b0; p_valid = 1'b1;
    in_valid = 1'b0; in_l = '0; in_r = '0; vol = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    check("rst_l", 32'(l), 32'h0);
    check("rst_r", 32'(r), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_underruns", 32'(underruns), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;

    // Underrun hold and saturation
    step(1'b1, 16'h1234, 16'h8000);
    wait_pop("t4_first");
    check("t4_pop_l", 32'(l), 32'h1234);
    check("t4_pop_r", 32'(r), 32'h8000);
    wait_pop("t4_under");
    check("t4_hold_l", 32'(l), UZ ? 32'h0 : 32'h1234);
    check("t4_hold_r", 32'(r), UZ ? 32'h0 : 32'h8000);
    check("t4_count1", 32'(underruns), 32'd1);
    check("t4_tick", 32'(tick), 32'h1);
    for (int i = 0; i < 300; i++) wait_pop("t4_starve");
    check("t4_sat", 32'(underruns), 32'd255);
    $display("txn underrun: 301 starved strobes, underruns=%0d", underruns);

    // Ordering and full: 17 pushes right after a pop, no pops in between
    for (int k = 0; k < 17; k++) begin
      check("t3_ready", 32'(in_ready), 32'(ord_tab[k].exp_ready));
      step(1'b1, ord_tab[k].l_in, ord_tab[k].r_in);
      check("t3_level", 32'(level), 32'(ord_tab[k].exp_level));
      $display("txn push k=%0d ready=%0b level=%0d", k + 1, ord_tab[k].exp_ready, level);
    end
    check("t3_full_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 16; k++) begin
      wait_pop("t3_pop");
      check("t3_pop_l", 32'(l), 32'(ord_tab[k].l_in));
      check("t3_pop_r", 32'(r), 32'(ord_tab[k].r_in));
      $display("txn pop k=%0d l=%0d r=%0d", k + 1, $signed(l), $signed(r));
    end

    // Push and pop in the same cycle at level 3
    step(1'b1, 16'h0A01, 16'h0B01);
    step(1'b1, 16'h0A02, 16'h0B02);
    step(1'b1, 16'h0A03, 16'h0B03);
    wait_pre_pop("t5");
    check("t5_level_before", 32'(level), 32'd3);
    step(1'b1, 16'h0A04, 16'h0B04);
    check("t5_level_after", 32'(level), 32'd3);
    check("t5_head_l", 32'(l), 32'h0A01);
    check("t5_head_r", 32'(r), 32'h0B01);
    $display("txn push+pop level=%0d l=%h", level, l);
    for (int k = 2; k <= 4; k++) begin
      wait_pop("t5_drain");
      check("t5_drain_l", 32'(l), 32'h0A00 + 32'(k));
    end

`ifdef PCM_VOLUME_EN
    for (int k = 0; k < 5; k++) begin
      vol = vol_tab[k].g;
      step(1'b1, vol_tab[k].s, vol_tab[k].s);
      wait_pop("t6");
      check("t6_vol_l", 32'(l), 32'(vol_tab[k].exp));
      check("t6_vol_r", 32'(r), 32'(vol_tab[k].exp));
      $display("txn vol=%0d s=%h out=%h", vol_tab[k].g, vol_tab[k].s, l);
    end
    vol = 8'd128;
`endif

    // Randomised traffic with phases that starve, fill and overflow
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0: thr = 10;
        1: thr = 2;
        2: thr = 30;
        default: thr = 4;
      endcase
`ifdef PCM_VOLUME_EN
      vol = 8'($urandom_range(0, 255));
`endif
      step($urandom_range(0, 99) < thr, 16'($urandom), 16'($urandom));
    end
    vol = 8'd128;
    $display("txn random done underruns=%0d level=%0d", underruns, level);

    // Reset mid-stream with 5 frames queued
    for (int i = 0; i < 20 && mq.size() > 0; i++) wait_pop("t1_drain");
    wait_pop("t1_align");
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h5000 + k), 16'(16'h6000 + k));
    check("t1_level5", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_l", 32'(l), 32'h0);
    check("t1_r", 32'(r), 32'h0);
    check("t1_level", 32'(level), 32'h0);
    check("t1_underruns", 32'(underruns), 32'h0);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    check("t1_tick", 32'(tick), 32'h0);
    $display("txn async reset level=%0d underruns=%0d", level, underruns);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) step($urandom_range(0, 99) < 8, 16'($urandom), 16'($urandom));

    // Let the 48 kHz instance run ~100 sample periods
    for (int i = 0; i < PACE_N + 4 && pace_cyc <= PACE_N; i++) step(1'b0, 16'h0, 16'h0);
    checks++;
    if (pace_ticks < 99 || pace_ticks > 101) begin
      failures++;
      $display("FAIL pace_count actual=%0d required=100+/-1", pace_ticks);
    end
    $display("txn pacing ticks=%0d in %0d clks", pace_ticks, PACE_N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
